// File: rtl/multi_dir_traffic_controller_pkg.sv
// Shared state encoding and lamp patterns for the multi-direction traffic controller.
package multi_dir_traffic_controller_pkg;

  typedef enum logic [1:0] {
    ALLRED = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2,
    FLASH  = 2'd3
  } tl_state_e;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  // Lamp pattern for one direction; owner means this direction holds the current phase.
  function automatic logic [2:0] lamp_for(input tl_state_e st, input logic owner, input logic toggle);
    logic [2:0] lamp;
    case (st)
      GREEN:   lamp = owner ? LAMP_GRN : LAMP_RED;
      YELLOW:  lamp = owner ? LAMP_YEL : LAMP_RED;
      FLASH:   lamp = toggle ? LAMP_YEL : LAMP_OFF;
      default: lamp = LAMP_RED;
    endcase
    return lamp;
  endfunction

endpackage

// File: rtl/multi_dir_traffic_controller_tl_interval_timer.sv
// Loadable down-counter that stops at zero; zero marks the last clock of an interval.
module tl_interval_timer #(
  parameter int             CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = {CNT_W{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != {CNT_W{1'b0}})) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/multi_dir_traffic_controller.sv
// Round-robin green/yellow/all-red sequencer for N_DIR approaches with pedestrian
// green extension and a flashing-yellow maintenance mode.
module multi_dir_traffic_controller
  import multi_dir_traffic_controller_pkg::*;
#(
  parameter int N_DIR          = 2,
  parameter int GREEN_CYCLES   = 8,
  parameter int YELLOW_CYCLES  = 3,
  parameter int ALLRED_CYCLES  = 2,
  parameter int PED_EXT_CYCLES = 4,
  parameter int FLASH_HALF     = 5,
  parameter int CNT_W          = 8,
  localparam int PH_W          = (N_DIR > 1) ? $clog2(N_DIR) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flash_en,
  input  logic [N_DIR-1:0]     ped_req,
  output logic [3*N_DIR-1:0]   lights,
  output logic [N_DIR-1:0]     walk,
  output logic [PH_W-1:0]      phase
);

  localparam logic [CNT_W-1:0] ALLRED_LD    = CNT_W'(ALLRED_CYCLES - 1);
  localparam logic [CNT_W-1:0] GREEN_LD     = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] GREEN_EXT_LD = CNT_W'(GREEN_CYCLES + PED_EXT_CYCLES - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD    = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLASH_LD     = CNT_W'(FLASH_HALF - 1);
  localparam logic [PH_W-1:0]  LAST_PH      = PH_W'(N_DIR - 1);

  tl_state_e            state_q, state_d;
  logic [PH_W-1:0]      phase_q, phase_d;
  logic                 served_q, served_d;
  logic                 toggle_q, toggle_d;
  logic [N_DIR-1:0]     ped_latch_q, ped_latch_d;
  logic [N_DIR-1:0]     ped_clr;
  logic [3*N_DIR-1:0]   lights_q, lights_d;
  logic [N_DIR-1:0]     walk_q, walk_d;

  logic                 st_load, st_dec, st_zero;
  logic [CNT_W-1:0]     st_load_val;
  logic                 fl_load, fl_dec, fl_zero;

  tl_interval_timer #(.CNT_W(CNT_W), .RST_VAL(ALLRED_LD)) u_state_timer (
    .clk(clk), .reset(reset), .load(st_load), .load_val(st_load_val), .dec(st_dec), .zero(st_zero)
  );

  tl_interval_timer #(.CNT_W(CNT_W), .RST_VAL(FLASH_LD)) u_flash_timer (
    .clk(clk), .reset(reset), .load(fl_load), .load_val(FLASH_LD), .dec(fl_dec), .zero(fl_zero)
  );

  // served_q remembers whether the current green was entered with its pedestrian latch set.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    served_d    = served_q;
    toggle_d    = toggle_q;
    ped_clr     = {N_DIR{1'b0}};
    st_load     = 1'b0;
    st_load_val = ALLRED_LD;
    st_dec      = 1'b0;
    fl_load     = 1'b0;
    fl_dec      = 1'b0;
    if (flash_en) begin
      served_d = 1'b0;
      if (state_q != FLASH) begin
        state_d  = FLASH;
        toggle_d = 1'b1;
        fl_load  = 1'b1;
      end else if (fl_zero) begin
        toggle_d = ~toggle_q;
        fl_load  = 1'b1;
      end else begin
        fl_dec = 1'b1;
      end
    end else begin
      case (state_q)
        ALLRED: begin
          if (st_zero) begin
            state_d     = GREEN;
            served_d    = ped_latch_q[phase_q];
            st_load     = 1'b1;
            st_load_val = ped_latch_q[phase_q] ? GREEN_EXT_LD : GREEN_LD;
          end else begin
            st_dec = 1'b1;
          end
        end
        GREEN: begin
          if (st_zero) begin
            state_d          = YELLOW;
            served_d         = 1'b0;
            ped_clr[phase_q] = served_q;
            st_load          = 1'b1;
            st_load_val      = YELLOW_LD;
          end else begin
            st_dec = 1'b1;
          end
        end
        YELLOW: begin
          if (st_zero) begin
            state_d     = ALLRED;
            phase_d     = (phase_q == LAST_PH) ? {PH_W{1'b0}} : phase_q + PH_W'(1);
            st_load     = 1'b1;
            st_load_val = ALLRED_LD;
          end else begin
            st_dec = 1'b1;
          end
        end
        FLASH: begin
          state_d     = ALLRED;
          phase_d     = {PH_W{1'b0}};
          toggle_d    = 1'b0;
          st_load     = 1'b1;
          st_load_val = ALLRED_LD;
        end
        default: begin
          state_d     = ALLRED;
          phase_d     = {PH_W{1'b0}};
          served_d    = 1'b0;
          toggle_d    = 1'b0;
          st_load     = 1'b1;
          st_load_val = ALLRED_LD;
        end
      endcase
    end
    // A new request on the clearing edge wins, so it is served on the next green.
    ped_latch_d = (ped_latch_q & ~ped_clr) | ped_req;
  end

  always_comb begin
    lights_d = {N_DIR{LAMP_RED}};
    walk_d   = {N_DIR{1'b0}};
    for (int i = 0; i < N_DIR; i++) begin
      lights_d[3*i +: 3] = lamp_for(state_d, phase_d == PH_W'(i), toggle_d);
      walk_d[i]          = (state_d == GREEN) && served_d && (phase_d == PH_W'(i));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ALLRED;
      phase_q     <= {PH_W{1'b0}};
      served_q    <= 1'b0;
      toggle_q    <= 1'b0;
      ped_latch_q <= {N_DIR{1'b0}};
      lights_q    <= {N_DIR{LAMP_RED}};
      walk_q      <= {N_DIR{1'b0}};
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      served_q    <= served_d;
      toggle_q    <= toggle_d;
      ped_latch_q <= ped_latch_d;
      lights_q    <= lights_d;
      walk_q      <= walk_d;
    end
  end

  assign lights = lights_q;
  assign walk   = walk_q;
  assign phase  = phase_q;

endmodule
